// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT/RUN/HALT control, branch/jump/jr selection, link register.
// Define PC_SEQUENCER_RAS_EN to add a circular return-address stack with prediction outputs.
module pc_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int JUMP_WIDTH = 26,
    parameter int PC_STEP = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int RAS_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  haltSignal,
    input  logic                  branchEqual,
    input  logic                  branchNotEqual,
    input  logic                  zero,
    input  logic                  jSignal,
    input  logic                  jalSignal,
    input  logic                  jrSignal,
    input  logic [ADDR_WIDTH-1:0] imm,
    input  logic [JUMP_WIDTH-1:0] jumpAddress,
    input  logic [ADDR_WIDTH-1:0] jumpRegister,
`ifdef PC_SEQUENCER_RAS_EN
    output logic                  rasEmpty,
    output logic [ADDR_WIDTH-1:0] rasPredict,
    output logic                  rasMiss,
`endif
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pcValid,
    output logic                  redirect,
    output logic [ADDR_WIDTH-1:0] linkAddress,
    output logic                  linkWrite,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pc_valid_q, pc_valid_d;
    logic                  redirect_q, redirect_d;
    logic [ADDR_WIDTH-1:0] link_addr_q, link_addr_d;
    logic                  link_write_q, link_write_d;
    logic                  halted_q, halted_d;

    logic [ADDR_WIDTH-1:0] pc_seq;
    logic [ADDR_WIDTH-1:0] jmp_target;
    logic                  br_taken;

    assign pc_seq     = pc_q + STEP;
    assign jmp_target = {pc_q[ADDR_WIDTH-1:JUMP_WIDTH], jumpAddress};
    assign br_taken   = (branchEqual & zero) | (branchNotEqual & ~zero);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        redirect_d   = redirect_q;
        link_addr_d  = link_addr_q;
        link_write_d = 1'b0;
        halted_d     = halted_q;
        case (state_q)
            BOOT: begin
                state_d    = RUN;
                pc_valid_d = 1'b1;
            end
            RUN: begin
                if (!stall) begin
                    if (haltSignal) begin
                        state_d    = HALT;
                        pc_valid_d = 1'b0;
                        halted_d   = 1'b1;
                        redirect_d = 1'b0;
                    end else begin
                        redirect_d = 1'b1;
                        if (br_taken) begin
                            pc_d = pc_q + imm;
                        end else if (jSignal || jalSignal) begin
                            pc_d = jmp_target;
                        end else if (jrSignal) begin
                            pc_d = jumpRegister;
                        end else begin
                            pc_d       = pc_seq;
                            redirect_d = 1'b0;
                        end
                        // A taken branch suppresses the link side effect of jal
                        if (jalSignal && !br_taken) begin
                            link_addr_d  = pc_seq;
                            link_write_d = 1'b1;
                        end
                    end
                end
            end
            HALT: begin
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            pc_valid_q   <= 1'b0;
            redirect_q   <= 1'b0;
            link_addr_q  <= '0;
            link_write_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            redirect_q   <= redirect_d;
            link_addr_q  <= link_addr_d;
            link_write_q <= link_write_d;
            halted_q     <= halted_d;
        end
    end

    assign pc          = pc_q;
    assign pcValid     = pc_valid_q;
    assign redirect    = redirect_q;
    assign linkAddress = link_addr_q;
    assign linkWrite   = link_write_q;
    assign halted      = halted_q;

`ifdef PC_SEQUENCER_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]         sp_q, sp_d, sp_m1;
    logic [PW:0]           cnt_q, cnt_d;
    logic                  miss_q, miss_d;
    logic                  run_go, push, pop;
    logic [ADDR_WIDTH-1:0] top;

    assign run_go = (state_q == RUN) & ~stall & ~haltSignal;
    assign push   = run_go & jalSignal & ~br_taken;
    // jr only pops when it actually selects the next pc
    assign pop    = run_go & jrSignal & ~br_taken & ~jSignal & ~jalSignal;
    assign sp_m1  = sp_q - PW'(1);
    assign top    = ras_q[sp_m1];

    always_comb begin
        ras_d  = ras_q;
        sp_d   = sp_q;
        cnt_d  = cnt_q;
        miss_d = 1'b0;
        if (push) begin
            ras_d[sp_q] = pc_seq;
            sp_d        = sp_q + PW'(1);
            if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
        end else if (pop) begin
            if (cnt_q == '0) begin
                miss_d = 1'b1;
            end else begin
                sp_d   = sp_m1;
                cnt_d  = cnt_q - 1'b1;
                miss_d = (top != jumpRegister);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sp_q   <= '0;
            cnt_q  <= '0;
            miss_q <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            cnt_q  <= cnt_d;
            miss_q <= miss_d;
        end
    end

    always_ff @(posedge clock) begin
        ras_q <= ras_d;
    end

    assign rasEmpty   = (cnt_q == '0);
    assign rasPredict = top;
    assign rasMiss    = miss_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic against a behavioural model.
// Define PC_SEQUENCER_RAS_EN to also exercise the return-address stack.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h100;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset, stall, haltSignal, branchEqual, branchNotEqual, zero;
    logic jSignal, jalSignal, jrSignal;
    logic [31:0] imm, jumpRegister;
    logic [25:0] jumpAddress;
    logic [31:0] pc, linkAddress;
    logic pcValid, redirect, linkWrite, halted;
`ifdef PC_SEQUENCER_RAS_EN
    logic rasEmpty, rasMiss;
    logic [31:0] rasPredict;
    logic [31:0] m_stack[$];
    bit m_miss;
`endif

    logic [31:0] m_pc, m_link;
    bit m_valid, m_redir, m_lw, m_halted, m_boot;
    int checks = 0;
    int failures = 0;

    pc_sequencer #(
        .ADDR_WIDTH(32), .JUMP_WIDTH(26), .PC_STEP(1),
        .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .haltSignal(haltSignal), .branchEqual(branchEqual),
        .branchNotEqual(branchNotEqual), .zero(zero),
        .jSignal(jSignal), .jalSignal(jalSignal), .jrSignal(jrSignal),
        .imm(imm), .jumpAddress(jumpAddress), .jumpRegister(jumpRegister),
`ifdef PC_SEQUENCER_RAS_EN
        .rasEmpty(rasEmpty), .rasPredict(rasPredict), .rasMiss(rasMiss),
`endif
        .pc(pc), .pcValid(pcValid), .redirect(redirect),
        .linkAddress(linkAddress), .linkWrite(linkWrite), .halted(halted)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next-state model derived directly from the behavioural rules
    function automatic void model_step();
        bit br;
        logic [31:0] seq, nxt, top;
        m_lw = 0;
`ifdef PC_SEQUENCER_RAS_EN
        m_miss = 0;
`endif
        if (reset) begin
            m_pc = RV; m_boot = 1; m_halted = 0; m_valid = 0;
            m_redir = 0; m_link = 0;
`ifdef PC_SEQUENCER_RAS_EN
            m_stack.delete();
`endif
        end else if (m_halted || stall && !m_boot) begin
        end else if (m_boot) begin
            m_boot = 0; m_valid = 1;
        end else if (haltSignal) begin
            m_halted = 1; m_valid = 0; m_redir = 0;
        end else begin
            br = (branchEqual && zero) || (branchNotEqual && !zero);
            seq = m_pc + 32'd1;
            if (jalSignal && !br) begin
                m_link = seq; m_lw = 1;
`ifdef PC_SEQUENCER_RAS_EN
                m_stack.push_back(seq);
                if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
`endif
            end
            m_redir = 1;
            if (br) nxt = m_pc + imm;
            else if (jSignal || jalSignal) nxt = {m_pc[31:26], jumpAddress};
            else if (jrSignal) begin
                nxt = jumpRegister;
`ifdef PC_SEQUENCER_RAS_EN
                if (m_stack.size() == 0) m_miss = 1;
                else begin
                    top = m_stack.pop_back();
                    m_miss = (top != jumpRegister);
                end
`endif
            end else begin
                nxt = seq; m_redir = 0;
            end
            m_pc = nxt;
        end
    endfunction

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("pcValid", 32'(pcValid), 32'(m_valid));
        chk("redirect", 32'(redirect), 32'(m_redir));
        chk("linkAddress", linkAddress, m_link);
        chk("linkWrite", 32'(linkWrite), 32'(m_lw));
        chk("halted", 32'(halted), 32'(m_halted));
`ifdef PC_SEQUENCER_RAS_EN
        chk("rasEmpty", 32'(rasEmpty), 32'(m_stack.size() == 0));
        chk("rasMiss", 32'(rasMiss), 32'(m_miss));
        if (m_stack.size() != 0) chk("rasPredict", rasPredict, m_stack[$]);
`endif
    endtask

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic clear();
        reset = 0; stall = 0; haltSignal = 0;
        branchEqual = 0; branchNotEqual = 0; zero = 0;
        jSignal = 0; jalSignal = 0; jrSignal = 0;
        imm = '0; jumpAddress = '0; jumpRegister = '0;
    endtask

    task automatic goto(input logic [31:0] a);
        clear();
        jrSignal = 1; jumpRegister = a;
        cyc();
        clear();
    endtask

    initial begin
        clear();
        reset = 1;
        cyc(); cyc();
        chk("reset_pc", pc, 32'h100);
        chk("reset_valid", 32'(pcValid), 32'd0);
        reset = 0;
        cyc();
        chk("boot_pc", pc, 32'h100);
        chk("boot_valid", 32'(pcValid), 32'd1);
        cyc(); chk("seq1", pc, 32'h101);
        cyc(); chk("seq2", pc, 32'h102);

        goto(32'h10);
        branchEqual = 1; zero = 1; imm = 32'hFFFF_FFFC;
        cyc();
        chk("beq_pc", pc, 32'h0C);
        chk("beq_redir", 32'(redirect), 32'd1);
        clear();
        branchNotEqual = 1; zero = 1;
        cyc();
        chk("bne_pc", pc, 32'h0D);
        chk("bne_redir", 32'(redirect), 32'd0);

        goto(32'hF400_0010);
        jalSignal = 1; jumpAddress = 26'h123;
        cyc();
        chk("jal_pc", pc, 32'hF400_0123);
        chk("jal_link", linkAddress, 32'hF400_0011);
        chk("jal_lw", 32'(linkWrite), 32'd1);
        clear();
        cyc();
        chk("jal_lw_pulse", 32'(linkWrite), 32'd0);

        stall = 1; jrSignal = 1; jumpRegister = 32'hABCD;
        repeat (3) cyc();
        chk("stall_pc", pc, 32'hF400_0124);
        stall = 0; jSignal = 1; jumpAddress = 26'h55;
        cyc();
        chk("j_over_jr", pc, 32'hF400_0055);

        goto(32'h20);
        haltSignal = 1;
        cyc();
        chk("halt_flag", 32'(halted), 32'd1);
        clear();
        branchEqual = 1; zero = 1; imm = 32'h8; jSignal = 1;
        repeat (3) cyc();
        chk("halt_pc", pc, 32'h20);
        clear();
        reset = 1;
        cyc();
        chk("rst_pc", pc, RV);
        chk("rst_halt", 32'(halted), 32'd0);
        reset = 0;
        cyc();

        goto(32'hFFFF_FFFF);
        cyc();
        chk("wrap", pc, 32'h0);

        repeat (600) begin
            reset = ($urandom_range(0, 99) < 2);
            stall = ($urandom_range(0, 99) < 15);
            haltSignal = ($urandom_range(0, 99) < 3);
            branchEqual = ($urandom_range(0, 99) < 20);
            branchNotEqual = ($urandom_range(0, 99) < 20);
            zero = $urandom_range(0, 1);
            jSignal = ($urandom_range(0, 99) < 10);
            jalSignal = ($urandom_range(0, 99) < 15);
            jrSignal = ($urandom_range(0, 99) < 20);
            imm = $urandom;
            jumpAddress = 26'($urandom);
            jumpRegister = $urandom;
            cyc();
        end

`ifdef PC_SEQUENCER_RAS_EN
        clear();
        reset = 1; cyc();
        reset = 0; cyc();
        for (int i = 0; i < 5; i++) begin
            jalSignal = 1; jumpAddress = 26'(i * 16 + 8);
            cyc();
            clear();
        end
        for (int i = 0; i < 5; i++) begin
            jrSignal = 1;
            jumpRegister = (m_stack.size() != 0) ? m_stack[$] : 32'h0;
            cyc();
            chk("ras_pop_miss", 32'(rasMiss), 32'(i == 4));
            clear();
        end
        chk("ras_empty_end", 32'(rasEmpty), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program counter unit for the single-cycle/multi-cycle MIPS-style datapath.
- Owns the PC register and selects the next PC from branch, jump, jump-and-link, jump-register or sequential sources.
- Adds reset vector, stall, halt state, registered link address and region-preserving jump targets.
- Sits between the control unit/ALU and instruction memory; drives the instruction memory address each cycle.

Parameters:
- ADDR_WIDTH, 32, width of PC, offsets and register targets.
- JUMP_WIDTH, 26, width of the jump instruction target field; must be < ADDR_WIDTH.
- PC_STEP, 1, sequential increment (1 = word addressed, 4 = byte addressed).
- RESET_VECTOR, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address-stack entries (optional feature only); power of two, at least 2.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and all state this cycle
- haltSignal  in  1  current instruction is halt
- branchEqual  in  1  instruction is beq
- branchNotEqual  in  1  instruction is bne
- zero  in  1  ALU result is zero
- jSignal  in  1  instruction is j
- jalSignal  in  1  instruction is jal
- jrSignal  in  1  instruction is jr
- imm  in  ADDR_WIDTH  sign-extended branch offset, in PC units
- jumpAddress  in  JUMP_WIDTH  jump target field
- jumpRegister  in  ADDR_WIDTH  register operand for jr
- pc  out  ADDR_WIDTH  current PC (registered)
- pcValid  out  1  pc addresses a live instruction
- redirect  out  1  registered: last update was non-sequential
- linkAddress  out  ADDR_WIDTH  registered return address from last jal
- linkWrite  out  1  one-cycle pulse: write linkAddress to $ra
- halted  out  1  sequencer in HALT state

Behaviour:
- Single clock, synchronous active-high reset.
- States: BOOT, RUN, HALT.
- Reset, from any state and overriding everything: state=BOOT, pc=RESET_VECTOR, pcValid=0, redirect=0, linkAddress=0, linkWrite=0, halted=0.
- BOOT: one cycle, pc unchanged, then state=RUN and pcValid=1.
- RUN with stall=1: all registers hold; linkWrite=0.
- RUN with stall=0: next pc is chosen by the first matching rule below.
  1. (branchEqual & zero) | (branchNotEqual & ~zero): pc+imm, redirect=1.
  2. jSignal | jalSignal: {pc[ADDR_WIDTH-1:JUMP_WIDTH], jumpAddress}, redirect=1.
  3. jrSignal: jumpRegister, redirect=1.
  4. Otherwise: pc+PC_STEP, redirect=0.
- Arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- jalSignal (unstalled, RUN, and not overridden by rule 1): linkAddress=pc+PC_STEP, linkWrite=1 for exactly that cycle; otherwise linkWrite=0.
- haltSignal in RUN, unstalled: highest priority over rules 1-4; pc holds, state=HALT, pcValid=0, halted=1, redirect=0.
- HALT: only reset exits; all control inputs ignored.
- Simultaneous jSignal and jrSignal: rule 2 wins.
- Latency: a decision made in cycle N is visible on pc after the rising edge ending cycle N.

Optional Feature:
- Macro: PC_SEQUENCER_RAS_EN.
- Defined: adds a RAS_DEPTH-entry circular return-address stack and extra output rasEmpty (1 bit).
  - jal pushes pc+PC_STEP. When full, the oldest entry is overwritten.
  - jr pops.
  - Output rasPredict (ADDR_WIDTH) shows the top of stack.
  - Output rasMiss (1 bit) pulses for one cycle when a jr target differs from the popped top, or when jr pops an empty stack (the pop is then a no-op).
  - Stack pointer and count reset to 0; stall freezes the stack.
- Undefined: no stack logic, and no rasEmpty, rasPredict or rasMiss ports.

Test Plan:
- Reset and boot, RESET_VECTOR=0x100: deassert reset -> pc=0x100, pcValid=0 for 1 cycle, then 1; next cycles pc=0x101, 0x102.
- beq taken then bne not taken: pc=0x10, imm=0xFFFFFFFC, branchEqual=1, zero=1 -> pc=0x0C, redirect=1; then branchNotEqual=1, zero=1 -> pc=0x0D, redirect=0.
- jal region and link: pc=0xF4000010, jumpAddress=0x0000123 -> pc=0xF4000123, linkAddress=0xF4000011, linkWrite high exactly 1 cycle.
- Stall and priority: stall=1 for 3 cycles with jrSignal=1 -> pc frozen; release with jSignal=jrSignal=1 -> jump target taken, not jumpRegister.
- Halt and reset mid-operation: haltSignal at pc=0x20 -> pc stays 0x20, halted=1, branches ignored; reset -> pc=RESET_VECTOR, halted=0.
- With PC_SEQUENCER_RAS_EN, RAS_DEPTH=4: 5 jals, then 5 jrs with matching targets -> first 4 pops rasMiss=0, fifth rasMiss=1 with rasEmpty=1.
